// File: rtl/mdu_pkg.sv
// Shared opcodes, state encoding and payload types for the multiply/divide unit.
// Build option MDU_MADD_EN adds the MADD/MADDU/MSUB/MSUBU accumulate opcodes.
package mdu_pkg;

  localparam int unsigned OP_W = 4;
  localparam int unsigned XLEN = 32;

  // Opcodes shared with decode and the hazard unit
  localparam logic [OP_W-1:0] NONE  = 4'd0;
  localparam logic [OP_W-1:0] MULT  = 4'd1;
  localparam logic [OP_W-1:0] MULTU = 4'd2;
  localparam logic [OP_W-1:0] DIV   = 4'd3;
  localparam logic [OP_W-1:0] DIVU  = 4'd4;
  localparam logic [OP_W-1:0] MTHI  = 4'd5;
  localparam logic [OP_W-1:0] MTLO  = 4'd6;
  localparam logic [OP_W-1:0] MFHI  = 4'd7;
  localparam logic [OP_W-1:0] MFLO  = 4'd8;
  localparam logic [OP_W-1:0] MADD  = 4'd9;
  localparam logic [OP_W-1:0] MADDU = 4'd10;
  localparam logic [OP_W-1:0] MSUB  = 4'd11;
  localparam logic [OP_W-1:0] MSUBU = 4'd12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
  } hilo_t;

  // Ops that run with the multiply latency
  function automatic logic is_mult_op(input logic [OP_W-1:0] op);
`ifdef MDU_MADD_EN
    return (op == MULT) || (op == MULTU) || (op == MADD) || (op == MADDU) ||
           (op == MSUB) || (op == MSUBU);
`else
    return (op == MULT) || (op == MULTU);
`endif
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

  // Ops whose operands are interpreted as two's complement
  function automatic logic is_signed_op(input logic [OP_W-1:0] op);
`ifdef MDU_MADD_EN
    return (op == MULT) || (op == DIV) || (op == MADD) || (op == MSUB);
`else
    return (op == MULT) || (op == DIV);
`endif
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit HI/LO result for the latched multiply/divide operation.
// With MDU_MADD_EN defined, also accumulates the product into the current HI/LO.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [OP_W-1:0] i_op,
  input  logic [XLEN-1:0] i_srca,
  input  logic [XLEN-1:0] i_srcb,
  input  hilo_t           i_hilo,
  output hilo_t           o_res_c
);

  localparam int unsigned DW = 2 * XLEN;

  logic            w_signed;
  logic [DW-1:0]   w_ma;
  logic [DW-1:0]   w_mb;
  logic [DW-1:0]   w_prod;
  logic            w_b_zero;
  logic [XLEN-1:0] w_dvd;
  logic [XLEN-1:0] w_dvs;
  logic [XLEN-1:0] w_uq;
  logic [XLEN-1:0] w_ur;
  logic [XLEN-1:0] w_q;
  logic [XLEN-1:0] w_r;

  assign w_signed = is_signed_op(i_op);

  // One 64x64 multiplier shared by signed/unsigned; low 64 bits are exact either way
  assign w_ma   = w_signed ? {{XLEN{i_srca[XLEN-1]}}, i_srca} : {XLEN'(0), i_srca};
  assign w_mb   = w_signed ? {{XLEN{i_srcb[XLEN-1]}}, i_srcb} : {XLEN'(0), i_srcb};
  assign w_prod = w_ma * w_mb;

  // Signed divide on magnitudes; the most-negative/-1 case falls out as 0x80000000 rem 0
  assign w_b_zero = (i_srcb == XLEN'(0));
  assign w_dvd    = (w_signed && i_srca[XLEN-1]) ? -i_srca : i_srca;
  assign w_dvs    = w_b_zero ? XLEN'(1) :
                    ((w_signed && i_srcb[XLEN-1]) ? -i_srcb : i_srcb);
  assign w_uq     = w_dvd / w_dvs;
  assign w_ur     = w_dvd % w_dvs;
  assign w_q      = (w_signed && (i_srca[XLEN-1] ^ i_srcb[XLEN-1])) ? -w_uq : w_uq;
  assign w_r      = (w_signed && i_srca[XLEN-1]) ? -w_ur : w_ur;

  always_comb begin
    o_res_c = i_hilo;
    case (i_op)
      MULT, MULTU: o_res_c = w_prod;
      DIV, DIVU: begin
        // Divide by zero leaves HI/LO untouched
        if (!w_b_zero) begin
          o_res_c.hi = w_r;
          o_res_c.lo = w_q;
        end
      end
`ifdef MDU_MADD_EN
      MADD, MADDU: o_res_c = i_hilo + w_prod;
      MSUB, MSUBU: o_res_c = i_hilo - w_prod;
`endif
      default: o_res_c = i_hilo;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// Execute-stage multiply/divide unit: fixed-latency FSM, busy flag and HI/LO registers.
// Build option MDU_MADD_EN enables the multiply-accumulate opcodes.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [OP_W-1:0] mdop,
  input  logic [XLEN-1:0] srca,
  input  logic [XLEN-1:0] srcb,
  output logic            buzy,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] mdout
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  state_e          r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [OP_W-1:0] r_op;
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic            r_buzy;

  hilo_t           w_hilo;
  hilo_t           w_res;
  logic            w_is_mult;
  logic            w_is_div;

  assign w_hilo    = {r_hi, r_lo};
  assign w_is_mult = is_mult_op(mdop);
  assign w_is_div  = is_div_op(mdop);

  mdu_arith u_arith (
    .i_op    (r_op),
    .i_srca  (r_a),
    .i_srcb  (r_b),
    .i_hilo  (w_hilo),
    .o_res_c (w_res)
  );

  // Control FSM; the result commits on the edge where the counter reads 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_op    <= NONE;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_buzy  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (w_is_mult || w_is_div) begin
              r_op    <= mdop;
              r_a     <= srca;
              r_b     <= srcb;
              r_cnt   <= w_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              r_state <= ST_RUN;
              r_buzy  <= 1'b1;
            end else if (mdop == MTHI) begin
              r_hi <= srca;
            end else if (mdop == MTLO) begin
              r_lo <= srca;
            end
          end
        end
        ST_RUN: begin
          if (r_cnt == CNT_W'(1)) begin
            r_hi    <= w_res.hi;
            r_lo    <= w_res.lo;
            r_cnt   <= '0;
            r_state <= ST_IDLE;
            r_buzy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign buzy  = r_buzy;
  assign hi    = r_hi;
  assign lo    = r_lo;
  // Read port for mfhi/mflo, combinational on the current opcode
  assign mdout = (mdop == MFHI) ? r_hi :
                 (mdop == MFLO) ? r_lo : XLEN'(0);

endmodule
